// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: default datapath width,
// ALU opcode encodings and the arbiter FSM state type.
package alu_pkg;

    localparam int DATA_W_DEF = 8;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOTA = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_SHR  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU. All results are truncated to DATA_W; carry and borrow
// are discarded.
// Ports:
//   i_a, i_b   operands
//   i_op       3-bit opcode (see alu_pkg)
//   o_result   ALU result
//   o_zero     high when o_result is all zeros
module alu
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [2:0]        i_op,
    output logic [DATA_W-1:0] o_result,
    output logic              o_zero
);

    // Opcode decode and result selection
    always_comb begin
        o_result = {DATA_W{1'b0}};
        case (i_op)
            OP_ADD:  o_result = i_a + i_b;
            OP_SUB:  o_result = i_a - i_b;
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_NOTA: o_result = ~i_a;
            OP_SHL:  o_result = {i_a[DATA_W-2:0], 1'b0};
            OP_SHR:  o_result = {1'b0, i_a[DATA_W-1:1]};
            default: o_result = {DATA_W{1'b0}};
        endcase
    end

    // Zero flag of the selected result
    always_comb begin
        o_zero = (o_result == {DATA_W{1'b0}});
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end to a single shared ALU.
// One operation is in flight at a time: IDLE (accept) -> EXEC (compute)
// -> RESP (hold result until consumed).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid/reqN_ready      requester N handshake (N = 0, 1)
//   reqN_a, reqN_b, reqN_op    requester N operands and opcode
//   rsp_valid/rsp_ready        response handshake
//   rsp_id                     requester that issued the response
//   rsp_result, rsp_zero       ALU result and its zero flag
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [2:0]        req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [2:0]        req1_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero
);

    state_t             r_state;
    logic               r_last_grant;
    logic [DATA_W-1:0]  r_op_a;
    logic [DATA_W-1:0]  r_op_b;
    logic [2:0]         r_op_code;
    logic               r_op_id;
    logic               r_rsp_valid;
    logic               r_rsp_id;
    logic [DATA_W-1:0]  r_rsp_result;
    logic               r_rsp_zero;

    logic               w_grant;
    logic               w_idle_ok;
    logic               w_ready0;
    logic               w_ready1;
    logic               w_accept;
    logic [DATA_W-1:0]  w_sel_a;
    logic [DATA_W-1:0]  w_sel_b;
    logic [2:0]         w_sel_op;
    logic [DATA_W-1:0]  w_alu_result;
    logic               w_alu_zero;

    // Round-robin grant: on a tie the requester not served last wins
    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end else begin
            w_grant = 1'b0;
        end
    end

    // Ready generation; gated by rst_n so neither ready rises during reset
    always_comb begin
        w_idle_ok = (r_state == ST_IDLE) && rst_n;
        w_ready0  = w_idle_ok && req0_valid && !w_grant;
        w_ready1  = w_idle_ok && req1_valid && w_grant;
        w_accept  = w_ready0 || w_ready1;
    end

    // Operand mux toward the operand registers
    always_comb begin
        w_sel_a  = req0_a;
        w_sel_b  = req0_b;
        w_sel_op = req0_op;
        if (w_grant) begin
            w_sel_a  = req1_a;
            w_sel_b  = req1_b;
            w_sel_op = req1_op;
        end else begin
            w_sel_a  = req0_a;
            w_sel_b  = req0_b;
            w_sel_op = req0_op;
        end
    end

    alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_a      (r_op_a),
        .i_b      (r_op_b),
        .i_op     (r_op_code),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero)
    );

    // Arbiter FSM with operand and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_op_a       <= {DATA_W{1'b0}};
            r_op_b       <= {DATA_W{1'b0}};
            r_op_code    <= 3'b000;
            r_op_id      <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= {DATA_W{1'b0}};
            r_rsp_zero   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op_a       <= w_sel_a;
                        r_op_b       <= w_sel_b;
                        r_op_code    <= w_sel_op;
                        r_op_id      <= w_grant;
                        r_last_grant <= w_grant;
                        r_state      <= ST_EXEC;
                    end else begin
                        r_state      <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    r_rsp_result <= w_alu_result;
                    r_rsp_zero   <= w_alu_zero;
                    r_rsp_id     <= r_op_id;
                    r_rsp_valid  <= 1'b1;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_state     <= ST_RESP;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req0_ready = w_ready0;
    assign req1_ready = w_ready1;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;

endmodule
